mem_arbiter: RTL

Two-port arbiter that shares the core's single-ported word memory between the instruction-fetch requester and the load/store (data) requester. Each cycle it grants at most one request and drives the memory port. It tracks in-flight reads through a MEM_LAT-deep tag pipeline so that each read response returns to the port that issued it. It sits between the fetch/decode_execute stages and the memory array in the top-level core.

---
 rtl/mem_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-ported word memory between fetch and load/store.
// Zero-latency grants with fetch anti-starvation, plus a tag pipeline that routes read data back.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [MEM_LAT-1:0]  tag_vld_q, tag_vld_d;
    logic [MEM_LAT-1:0]  tag_port_q, tag_port_d;
    logic                if_win, ls_win;

    // Data wins contests until it has starved fetch STARVE_MAX times in a row.
    always_comb begin
        if_win = 1'b0;
        ls_win = 1'b0;
        if (!reset) begin
            if (if_req && ls_req) begin
                if (streak_q == STREAK_MAX) begin
                    if_win = 1'b1;
                end else begin
                    ls_win = 1'b1;
                end
            end else begin
                if_win = if_req;
                ls_win = ls_req;
            end
        end
    end

    assign if_gnt    = if_win;
    assign ls_gnt    = ls_win;
    assign mem_en    = if_win | ls_win;
    assign mem_we    = ls_win & ls_we;
    assign mem_addr  = reset ? '0 : (ls_win ? ls_addr : if_addr);
    assign mem_wdata = reset ? '0 : ls_wdata;

    always_comb begin
        streak_d = streak_q;
        if (!if_req || if_win) begin
            streak_d = '0;
        end else if (ls_win && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    // Stage 0 captures each read grant's owner; the last stage lines up with mem_rdata.
    always_comb begin
        tag_vld_d     = '0;
        tag_port_d    = '0;
        tag_vld_d[0]  = mem_en & ~mem_we;
        tag_port_d[0] = ls_win;
        for (int i = 1; i < int'(MEM_LAT); i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_port_d[i] = tag_port_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q   <= '0;
            tag_vld_q  <= '0;
            tag_port_q <= '0;
        end else begin
            streak_q   <= streak_d;
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
        end
    end

    assign if_rvalid = ~reset & tag_vld_q[MEM_LAT-1] & ~tag_port_q[MEM_LAT-1];
    assign ls_rvalid = ~reset & tag_vld_q[MEM_LAT-1] &  tag_port_q[MEM_LAT-1];
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;

endmodule
